// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, credit-limited memory requests, in-order instruction FIFO, branch redirect.
// Optional FETCH_PERF_EN adds stall/flush/drop performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instrPc,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount,
  output logic [31:0] dropCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];

  logic          credit, accept, resp_drop, push, pop;
  logic [31:0]   resp_pc;

  // Requests in flight plus buffered entries never exceed DEPTH, so the FIFO cannot overflow.
  assign credit    = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign imemReq   = rst_n && credit;
  assign imemAddr  = pc_q;
  assign accept    = imemReq && imemReady;
  assign resp_drop = drop_cnt_q != '0;
  assign push      = imemRvalid && !resp_drop && !branchTaken;
  assign pop       = instrValid && instrReady && !branchTaken;
  // Non-discarded in-flight requests are consecutive words ending just below pc_q.
  assign resp_pc   = pc_q - (32'(outstanding_q) << 2);

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imemRvalid);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (accept) pc_d = pc_q + 32'd4;
    if (imemRvalid && resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (branchTaken) begin
      pc_d       = branchTarget & ~32'h3;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imemRdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc;
    end
  end

  assign instrValid = count_q != '0;
  assign instr      = instrValid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign instrPc    = instrValid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign opcode     = instr[31:26];

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    drop_count_d   = drop_count_q;
    if ((imemReq && !imemReady) || !credit) stall_cycles_d = stall_cycles_q + 32'd1;
    if (branchTaken) flush_count_d = flush_count_q + 32'd1;
    if (imemRvalid && (resp_drop || branchTaken)) drop_count_d = drop_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      drop_count_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
  assign dropCount   = drop_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a latency-configurable instruction memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b1;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instrPc;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
`ifdef FETCH_PERF_EN
  logic [31:0] stallCycles, flushCount, dropCount;
`endif

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
    .opcode(opcode), .instrPc(instrPc),
    .branchTaken(branchTaken), .branchTarget(branchTarget)
`ifdef FETCH_PERF_EN
    , .stallCycles(stallCycles), .flushCount(flushCount), .dropCount(dropCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] addr; } req_t;
  req_t        memq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_toggle = 1'b0;
  logic [31:0] mem_exp = 32'h0;
  logic [31:0] mon_pc = 32'h0;
  logic [31:0] mon_exp;
  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[7:2] ^ 6'h2A, 10'h155, a[15:0]};
  endfunction

  // Memory: record accepts and check the address stream has no skips or duplicates.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      memq.delete();
      mem_exp = 32'h0;
    end else begin
      if (imemReq && imemReady) begin
        n_checks++;
        if (imemAddr !== mem_exp) begin
          n_fail++;
          $display("[TB] FAIL req_addr: got %h expected %h", imemAddr, mem_exp);
        end
        memq.push_back('{cyc, imemAddr});
        acc_cnt++;
        mem_exp = mem_exp + 32'd4;
      end
      if (branchTaken) mem_exp = branchTarget & ~32'h3;
    end
  end

  always @(negedge clk) begin
    imemReady = mem_toggle ? ~imemReady : 1'b1;
    if (memq.size() > 0 && (cyc - memq[0].cyc) >= mem_lat - 1) begin
      imemRvalid = 1'b1;
      imemRdata  = data_of(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
    end
  end

  // Consumer model: every popped instruction must be the next sequential one since reset/redirect.
  always @(posedge clk) begin
    if (!rst_n) mon_pc = 32'h0;
    else if (branchTaken) mon_pc = branchTarget & ~32'h3;
    else if (instrValid && instrReady) begin
      mon_exp = data_of(mon_pc);
      n_checks++;
      if (instrPc !== mon_pc || instr !== mon_exp || opcode !== mon_exp[31:26]) begin
        n_fail++;
        $display("[TB] FAIL pop_order: got pc %h instr %h op %h expected pc %h instr %h",
                 instrPc, instr, opcode, mon_pc, mon_exp);
      end
      mon_pc = mon_pc + 32'd4;
      pop_cnt++;
    end
  end

  task automatic do_reset(input int lat, input bit tog);
    @(negedge clk);
    rst_n = 1'b0; instrReady = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
    mem_lat = lat; mem_toggle = tog;
    repeat (2) @(negedge clk);
    acc_cnt = 0; pop_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instrValid); end
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imemReq); end
    n_checks++; if (instr !== 32'h0 || opcode !== 6'h0 || instrPc !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_head: got %h %h %h expected zeros", instr, opcode, instrPc);
    end
    n_checks++; if (imemAddr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 0", imemAddr); end
`ifdef FETCH_PERF_EN
    n_checks++; if (stallCycles !== 0 || flushCount !== 0 || dropCount !== 0) begin
      n_fail++; $display("[TB] FAIL reset_perf: got %h %h %h expected zeros", stallCycles, flushCount, dropCount);
    end
`endif
  endtask

  task automatic test_stream;
    do_reset(1, 1'b0);
    instrReady = 1'b1;
    @(negedge clk);
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_c2_valid: got %b expected 0", instrValid); end
    n_checks++; if (imemAddr !== 32'h4) begin n_fail++; $display("[TB] FAIL stream_c2_addr: got %h expected 4", imemAddr); end
    @(negedge clk);
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
      n_fail++; $display("[TB] FAIL stream_c3_head: got v %b pc %h expected v 1 pc 0", instrValid, instrPc);
    end
    n_checks++; if (instr !== 32'hA955_0000 || opcode !== 6'h2A) begin
      n_fail++; $display("[TB] FAIL stream_c3_instr: got %h op %h expected a9550000 op 2a", instr, opcode);
    end
    repeat (10) @(negedge clk);
    n_checks++; if (pop_cnt !== 7) begin n_fail++; $display("[TB] FAIL stream_pops: got %0d expected 7", pop_cnt); end
    n_checks++; if (acc_cnt !== 8) begin n_fail++; $display("[TB] FAIL stream_accepts: got %0d expected 8", acc_cnt); end
  endtask

  task automatic test_stall;
    do_reset(1, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++; if (acc_cnt !== 2) begin n_fail++; $display("[TB] FAIL stall_accepts: got %0d expected 2", acc_cnt); end
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_req: got %b expected 0", imemReq); end
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0 || imemAddr !== 32'h8) begin
      n_fail++; $display("[TB] FAIL stall_state: got v %b pc %h addr %h expected 1 0 8", instrValid, instrPc, imemAddr);
    end
    instrReady = 1'b1;
    @(negedge clk);
    n_checks++; if (instrPc !== 32'h4 || imemReq !== 1'b1 || imemAddr !== 32'h8) begin
      n_fail++; $display("[TB] FAIL stall_resume: got pc %h req %b addr %h expected 4 1 8", instrPc, imemReq, imemAddr);
    end
    @(negedge clk);
    n_checks++; if (acc_cnt !== 3) begin n_fail++; $display("[TB] FAIL stall_reissue: got %0d expected 3", acc_cnt); end
    instrReady = 1'b0;
  endtask

  task automatic test_ready_toggle;
    do_reset(3, 1'b1);
    instrReady = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (pop_cnt < 6) begin n_fail++; $display("[TB] FAIL toggle_progress: got %0d pops expected at least 6", pop_cnt); end
    mem_toggle = 1'b0;
  endtask

  task automatic test_branch;
    bit found;
    do_reset(3, 1'b0);
    instrReady = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("[TB] FAIL br_inflight: got req %b expected 0", imemReq); end
    branchTaken = 1'b1; branchTarget = 32'h100;
    @(negedge clk);
    branchTaken = 1'b0;
    n_checks++; if (instrValid !== 1'b0 || imemAddr !== 32'h100 || imemReq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL br_after: got v %b addr %h req %b expected 0 100 0", instrValid, imemAddr, imemReq);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (instrValid) found = 1'b1; end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL br_timeout: got no valid expected valid within 20"); end
    n_checks++; if (instrPc !== 32'h100 || instr !== 32'hA955_0100) begin
      n_fail++; $display("[TB] FAIL br_target: got pc %h instr %h expected 100 a9550100", instrPc, instr);
    end
  endtask

  task automatic test_branch_coincident;
    bit found;
    do_reset(1, 1'b0);
    instrReady = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (instrValid !== 1'b1) begin n_fail++; $display("[TB] FAIL co_pre: got v %b expected 1", instrValid); end
    branchTaken = 1'b1; branchTarget = 32'h203;
    @(negedge clk);
    branchTaken = 1'b0;
    n_checks++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      n_fail++; $display("[TB] FAIL co_after: got v %b req %b addr %h expected 0 1 200", instrValid, imemReq, imemAddr);
    end
    n_checks++; if (pop_cnt !== 0) begin n_fail++; $display("[TB] FAIL co_pop: got %0d expected 0", pop_cnt); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (instrValid) found = 1'b1; end
    n_checks++; if (!found || instrPc !== 32'h200 || instr !== 32'hA955_0200) begin
      n_fail++; $display("[TB] FAIL co_target: got v %b pc %h instr %h expected 1 200 a9550200", found, instrPc, instr);
    end
  endtask

  task automatic test_back_to_back;
    bit found;
    do_reset(3, 1'b0);
    instrReady = 1'b1;
    @(negedge clk);
    branchTaken = 1'b1; branchTarget = 32'h300;
    @(negedge clk);
    branchTaken = 1'b1; branchTarget = 32'h384;
    @(negedge clk);
    branchTaken = 1'b0;
    n_checks++; if (imemAddr !== 32'h384 || instrValid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_after: got addr %h v %b expected 384 0", imemAddr, instrValid);
    end
    found = 1'b0;
    for (int i = 0; i < 25 && !found; i++) begin @(negedge clk); if (instrValid) found = 1'b1; end
    n_checks++; if (!found || instrPc !== 32'h384 || instr !== 32'h2D55_0384) begin
      n_fail++; $display("[TB] FAIL b2b_target: got v %b pc %h instr %h expected 1 384 2d550384", found, instrPc, instr);
    end
  endtask

  task automatic test_reset_midstream;
    bit found;
    do_reset(1, 1'b0);
    instrReady = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_reset: got v %b req %b expected 0 0", instrValid, imemReq);
    end
`ifdef FETCH_PERF_EN
    n_checks++; if (stallCycles !== 0 || flushCount !== 0 || dropCount !== 0) begin
      n_fail++; $display("[TB] FAIL mid_perf: got %h %h %h expected zeros", stallCycles, flushCount, dropCount);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL mid_restart: got req %b addr %h expected 1 0", imemReq, imemAddr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (instrValid) found = 1'b1; end
    n_checks++; if (!found || instrPc !== 32'h0) begin
      n_fail++; $display("[TB] FAIL mid_first: got v %b pc %h expected 1 0", found, instrPc);
    end
  endtask

  initial begin
    $display("[TB] instr_fetch directed test start");
    test_reset();
    test_stream();
    test_stall();
    test_ready_toggle();
    test_branch();
    test_branch_coincident();
    test_back_to_back();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
